keypad_matrix_driver: RTL and testbench
=======================================

# keypad_matrix_driver

Synthesizable stand-in for a 4x4 membrane keypad, sitting on the far side of the row/column interface that the `keyboard` scanner drives. Key-press commands arrive on a valid/ready stream and are buffered in a small FIFO. Each command is replayed as a physical press: for a fixed time the selected column is pulled low whenever the scanner drives the matching row, then a fixed gap follows. It is used for on-board self-test and for scripted move entry, in place of the real keypad.

## Interface
- `HOLD_CYCLES`, default 25000: clk cycles a key is held pressed; must be ≥1.
- `GAP_CYCLES`, default 25000: clk cycles of forced release after each press; must be ≥1.
- `FIFO_DEPTH`, default 4: command buffer entries; power of two, ≥2.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `en`  in  1  high permits starting new presses.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept a command.
- `cmd_index`  in  4  key to press: `[3:2]` is the row, `[1:0]` is the column.
- `keyboard_row`  in  4  active-low row drive from the scanner.
- `keyboard_col`  out  4  active-low column sense back to the scanner.
- `press_active`  out  1  a key is currently held.
- `press_index`  out  4  index of the held or last-held key.
- `release_pulse`  out  1  one-cycle strobe at the start of each gap.
- `busy`  out  1  state ≠ IDLE or FIFO non-empty.
- `fifo_count`  out  log2(FIFO_DEPTH)+1  number of entries buffered.

## Operation
- **Encoding.**
  - Row r is selected when `keyboard_row[3-r]` is low.
  - Column c is reported by driving `keyboard_col[3-c]` low; every other column bit stays high.
- **Multiple rows low.** The highest-numbered low bit of `keyboard_row` wins. Example: `0011` selects row 0.
- **Column output.**
  - Combinational from `keyboard_row` and the registered press state.
  - `keyboard_col = ~(4'b1000 >> press_index[1:0])` when `press_active` is high and the selected row equals `press_index[3:2]`.
  - Otherwise `1111`, including when `keyboard_row` = `1111`.
- **FIFO.**
  - `cmd_ready = (fifo_count != FIFO_DEPTH)`.
  - A write occurs on an edge where `cmd_valid && cmd_ready`.
  - Read and write may happen on the same edge; `fifo_count` is then unchanged.
  - When full, `cmd_ready` is low even if a read happens that cycle; there is no same-cycle refill.
  - There is no bypass path: a command written into an empty FIFO is read no earlier than the next cycle.
  - Pointers wrap modulo `FIFO_DEPTH`; order is strictly FIFO.
- **FSM states and transitions.**
  - IDLE → PRESS on an edge where `en` is high and the FIFO is non-empty. That edge pops the head into `press_index`, sets `press_active`, and loads the counter with `HOLD_CYCLES-1`.
  - PRESS: the counter decrements each cycle. At 0: go to GAP, clear `press_active`, load the counter with `GAP_CYCLES-1`, and assert `release_pulse` for that first GAP cycle.
  - GAP: the counter decrements each cycle. At 0: go to IDLE.
- **`en` low.**
  - Blocks only the IDLE → PRESS transition.
  - A press in progress completes its full hold and gap.
  - The FIFO still accepts commands.
- **Counter width.** `$clog2(max(HOLD_CYCLES, GAP_CYCLES))`, minimum 1.
- **Reset (also mid-operation).** FIFO flushed; FSM to IDLE. Output values:
  - `press_active` = 0, `press_index` = 0, `release_pulse` = 0, `fifo_count` = 0, `busy` = 0, `cmd_ready` = 1.
  - `keyboard_col` = `1111` from the cycle after the reset edge.

## Timing
- **Acceptance to press.** Command accepted at edge E0 into an empty FIFO with FSM in IDLE and `en` high: popped at E1; `press_active` is high in the cycles after E1.
- **Hold.** `press_active` is high for exactly `HOLD_CYCLES` cycles.
- **Gap and IDLE.** GAP lasts exactly `GAP_CYCLES` cycles, followed by at least one IDLE cycle.
- **Back-to-back presses.** Minimum spacing between press starts is `HOLD_CYCLES + GAP_CYCLES + 1` cycles.
- **Column response.** Combinational: no clk latency from `keyboard_row` to `keyboard_col` while held. The scanner's sampling clock may be asynchronous to `clk`.

## Test plan
Parameters: `HOLD_CYCLES`=4, `GAP_CYCLES`=3, `FIFO_DEPTH`=4.

- **Reset.** Hold reset, sweep `keyboard_row` through `0111`, `1011`, `1101`, `1110` → `keyboard_col` = `1111` for all; `cmd_ready` = 1, `busy` = 0, `fifo_count` = 0.
- **Single press.** `en`=1; accept `cmd_index`=4'h6 at cycle 0.
  - `press_active` high in cycles 2–5, `press_index`=6.
  - During the hold: `keyboard_row`=`1011` → `keyboard_col`=`1101`; `keyboard_row`=`0111` → `1111`.
  - `release_pulse` high only in cycle 6; GAP occupies cycles 6–8; `busy` falls in cycle 9.
- **FIFO full.** With `en`=0, offer 5, A, E, F, 0 on consecutive cycles.
  - First four accepted; `cmd_ready` low after the fourth; `fifo_count`=4; the 0 is held off.
  - Raise `en` → presses occur in order 5, A, E, F, then 0 once `cmd_ready` rises; press starts are 8 cycles apart.
- **`en` dropped mid-press.**
  - Deassert `en` in cycle 3 of a press → hold ends at cycle 5 as normal.
  - Queued next command is not popped; `busy` stays 1.
  - It is popped on the first edge after `en` rises once the FSM is back in IDLE.
- **Row priority.** Hold key 4'h1 (row 0, col 1); drive `keyboard_row`=`0011` → `keyboard_col`=`1011`. Drive `1111` → `1111`.
- **Reset mid-press.** Assert `rst_n`=0 in cycle 3 of a press with 2 entries queued → next cycle `press_active`=0, `keyboard_col`=`1111`, `fifo_count`=0. After release, no stale command is replayed.

Source files
------------

// File: rtl/keypad_matrix_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : keypad_matrix_driver_if
// Description : Bundle between a keypad command source / row scanner and the
//               keypad_matrix_driver.
//               master : command source + scanner side (drives en, cmd_valid,
//                        cmd_index, keyboard_row; observes the rest)
//               slave  : keypad_matrix_driver side
//               Signals:
//                 en            press-start permission
//                 cmd_valid     command present
//                 cmd_ready     FIFO can accept a command
//                 cmd_index     [3:2] row, [1:0] column of key to press
//                 keyboard_row  active-low row drive from the scanner
//                 keyboard_col  active-low column sense to the scanner
//                 press_active  a key is currently held
//                 press_index   held / last-held key
//                 release_pulse one-cycle strobe at the start of each gap
//                 busy          press in progress or commands buffered
//                 fifo_count    number of buffered commands
// Revision    : 1.0 - initial release
// ============================================================================
interface keypad_matrix_driver_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int c_count_w = $clog2(FIFO_DEPTH) + 1;

    logic                 en;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [3:0]           cmd_index;
    logic [3:0]           keyboard_row;
    logic [3:0]           keyboard_col;
    logic                 press_active;
    logic [3:0]           press_index;
    logic                 release_pulse;
    logic                 busy;
    logic [c_count_w-1:0] fifo_count;

    modport master (
        output en, cmd_valid, cmd_index, keyboard_row,
        input  cmd_ready, keyboard_col, press_active, press_index,
               release_pulse, busy, fifo_count
    );

    modport slave (
        input  en, cmd_valid, cmd_index, keyboard_row,
        output cmd_ready, keyboard_col, press_active, press_index,
               release_pulse, busy, fifo_count
    );
endinterface
`default_nettype wire

// File: rtl/keypad_matrix_driver.sv
`default_nettype none
// ============================================================================
// Module      : keypad_matrix_driver
// Description : Synthesizable stand-in for a 4x4 membrane keypad. Buffers
//               key-press commands in a FIFO and replays each one as a
//               physical press (column pulled low while its row is scanned)
//               for HOLD_CYCLES, followed by a GAP_CYCLES forced release.
//               Ports:
//                 clk    system clock
//                 rst_n  synchronous active-low reset
//                 bus    keypad_matrix_driver_if.slave (command stream,
//                        row/column matrix, press status)
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_matrix_driver #(
    parameter int HOLD_CYCLES = 25000,
    parameter int GAP_CYCLES  = 25000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    keypad_matrix_driver_if.slave bus
);

    localparam int c_ptr_w      = $clog2(FIFO_DEPTH);
    localparam int c_max_cycles = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int c_cnt_w      = (c_max_cycles > 1) ? $clog2(c_max_cycles) : 1;

    localparam logic [c_cnt_w-1:0] c_hold_load = c_cnt_w'(HOLD_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_gap_load  = c_cnt_w'(GAP_CYCLES - 1);
    localparam logic [c_ptr_w:0]   c_full      = (c_ptr_w + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [3:0]         fifo_mem_q [FIFO_DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q;
    logic [c_ptr_w-1:0] rd_ptr_q;
    logic [c_ptr_w:0]   count_q;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;

    assign w_full  = (count_q == c_full);
    assign w_empty = (count_q == '0);
    // Readiness depends only on the registered count, so a pop in the same
    // cycle never opens a slot for a simultaneous write when full.
    assign w_push  = bus.cmd_valid && !w_full;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            fifo_mem_q[wr_ptr_q] <= bus.cmd_index;
        end
    end

    // ------------------------------------------------------------------
    // Press sequencer
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic               press_active_q, press_active_d;
    logic [3:0]         press_index_q, press_index_d;
    logic               release_q, release_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            press_active_q <= 1'b0;
            press_index_q  <= 4'd0;
            release_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            press_active_q <= press_active_d;
            press_index_q  <= press_index_d;
            release_q      <= release_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        press_active_d = press_active_q;
        press_index_d  = press_index_q;
        release_d      = 1'b0;
        w_pop          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The head is read from registered storage, so a command
                // written this edge cannot be popped until the next one.
                if (bus.en && !w_empty) begin
                    w_pop          = 1'b1;
                    state_d        = ST_PRESS;
                    press_active_d = 1'b1;
                    press_index_d  = fifo_mem_q[rd_ptr_q];
                    cnt_d          = c_hold_load;
                end
            end
            ST_PRESS: begin
                if (cnt_q == '0) begin
                    state_d        = ST_GAP;
                    press_active_d = 1'b0;
                    cnt_d          = c_gap_load;
                    release_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Matrix response: purely combinational from the scanner's row drive
    // so an asynchronous scanner sees the column with no clk latency.
    // ------------------------------------------------------------------
    logic       w_row_hit;
    logic [1:0] w_row_sel;

    always_comb begin
        w_row_hit = 1'b0;
        w_row_sel = 2'd0;
        // Ascending scan: the highest low bit (lowest row number) wins.
        for (int i = 0; i < 4; i++) begin
            if (!bus.keyboard_row[i]) begin
                w_row_hit = 1'b1;
                w_row_sel = 2'(3 - i);
            end
        end
    end

    assign bus.keyboard_col = (press_active_q && w_row_hit && (w_row_sel == press_index_q[3:2]))
                            ? ~(4'b1000 >> press_index_q[1:0])
                            : 4'b1111;

    assign bus.cmd_ready     = !w_full;
    assign bus.press_active  = press_active_q;
    assign bus.press_index   = press_index_q;
    assign bus.release_pulse = release_q;
    assign bus.busy          = (state_q != ST_IDLE) || !w_empty;
    assign bus.fifo_count    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_matrix_driver
// Description : Self-checking bench for keypad_matrix_driver with
//               HOLD_CYCLES=4, GAP_CYCLES=3, FIFO_DEPTH=4. Directed scenario
//               tasks plus a randomized run against a timeline-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_matrix_driver;

    localparam int c_hold  = 4;
    localparam int c_gap   = 3;
    localparam int c_depth = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    keypad_matrix_driver_if #(.FIFO_DEPTH(c_depth)) kif ();

    keypad_matrix_driver #(
        .HOLD_CYCLES (c_hold),
        .GAP_CYCLES  (c_gap),
        .FIFO_DEPTH  (c_depth)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (kif)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: a queue of commands plus the edge number at which
    // the current press started; everything else is derived from elapsed
    // edges since that start.
    // ------------------------------------------------------------------
    logic [3:0] mq [$];
    bit         m_started = 1'b0;
    int         m_start   = 0;
    logic [3:0] m_idx     = 4'd0;
    int         ecount    = 0;

    function automatic bit m_active();
        return m_started && (ecount - m_start < c_hold);
    endfunction

    function automatic bit m_release();
        return m_started && (ecount - m_start == c_hold);
    endfunction

    function automatic bit m_busy();
        return (m_started && (ecount - m_start < c_hold + c_gap)) || (mq.size() > 0);
    endfunction

    function automatic logic [3:0] exp_col(input logic [3:0] row, input bit active,
                                           input logic [3:0] key);
        int         sel_row;
        logic [3:0] col;
        sel_row = -1;
        for (int r = 3; r >= 0; r--) begin
            if (row[3 - r] == 1'b0) sel_row = r;
        end
        col = 4'b1111;
        if (active && sel_row == int'(key[3:2])) col[3 - int'(key[1:0])] = 1'b0;
        return col;
    endfunction

    task automatic tick();
        bit idle;
        bit full;
        @(posedge clk);
        ecount++;
        if (!rst_n) begin
            mq.delete();
            m_started = 1'b0;
            m_idx     = 4'd0;
        end else begin
            idle = !m_started || (ecount - m_start > c_hold + c_gap);
            full = (mq.size() == c_depth);
            if (idle && kif.en && mq.size() > 0) begin
                m_idx     = mq.pop_front();
                m_started = 1'b1;
                m_start   = ecount;
            end
            if (kif.cmd_valid && !full) mq.push_back(kif.cmd_index);
        end
        #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [3:0] rows [4];
        rows[0] = 4'b0111; rows[1] = 4'b1011; rows[2] = 4'b1101; rows[3] = 4'b1110;
        rst_n = 1'b0;
        kif.en = 1'b0; kif.cmd_valid = 1'b0; kif.cmd_index = 4'd0; kif.keyboard_row = 4'b1111;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            kif.keyboard_row = rows[i];
            #1;
            n_tests++;
            if (kif.keyboard_col !== 4'b1111) begin
                n_fail++;
                $display("FAIL reset_col row=%b got=%b exp=1111", rows[i], kif.keyboard_col);
            end
        end
        n_tests++;
        if (kif.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", kif.cmd_ready); end
        n_tests++;
        if (kif.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", kif.busy); end
        n_tests++;
        if (kif.fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", kif.fifo_count); end
        n_tests++;
        if (kif.press_active !== 1'b0 || kif.press_index !== 4'd0 || kif.release_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_press got act=%b idx=%h rel=%b exp 0/0/0",
                     kif.press_active, kif.press_index, kif.release_pulse);
        end
        kif.keyboard_row = 4'b1111;
        rst_n = 1'b1;
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_single_press();
        kif.en = 1'b1; kif.cmd_index = 4'h6; kif.cmd_valid = 1'b1;
        tick();
        kif.cmd_valid = 1'b0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            n_tests++;
            if (kif.press_active !== (cyc >= 2 && cyc <= 5)) begin
                n_fail++;
                $display("FAIL single_active cyc=%0d got=%b exp=%b", cyc, kif.press_active, (cyc >= 2 && cyc <= 5));
            end
            n_tests++;
            if (kif.release_pulse !== (cyc == 6)) begin
                n_fail++;
                $display("FAIL single_release cyc=%0d got=%b exp=%b", cyc, kif.release_pulse, (cyc == 6));
            end
            n_tests++;
            if (kif.busy !== (cyc <= 8)) begin
                n_fail++;
                $display("FAIL single_busy cyc=%0d got=%b exp=%b", cyc, kif.busy, (cyc <= 8));
            end
            if (cyc == 2) begin
                n_tests++;
                if (kif.press_index !== 4'h6) begin
                    n_fail++; $display("FAIL single_index got=%h exp=6", kif.press_index);
                end
            end
            if (cyc == 3) begin
                kif.keyboard_row = 4'b1011;
                #1;
                n_tests++;
                if (kif.keyboard_col !== 4'b1101) begin
                    n_fail++; $display("FAIL single_col_hit got=%b exp=1101", kif.keyboard_col);
                end
                kif.keyboard_row = 4'b0111;
                #1;
                n_tests++;
                if (kif.keyboard_col !== 4'b1111) begin
                    n_fail++; $display("FAIL single_col_miss got=%b exp=1111", kif.keyboard_col);
                end
                kif.keyboard_row = 4'b1111;
            end
            tick();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_fifo_full();
        logic [3:0] vals [5];
        logic [3:0] st_idx [$];
        int         st_cyc [$];
        bit         prev;
        bit         acc;
        vals[0] = 4'h5; vals[1] = 4'hA; vals[2] = 4'hE; vals[3] = 4'hF; vals[4] = 4'h0;
        kif.en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            kif.cmd_index = vals[i]; kif.cmd_valid = 1'b1;
            tick();
            n_tests++;
            if (kif.fifo_count !== 3'(i + 1)) begin
                n_fail++; $display("FAIL full_fill_count i=%0d got=%0d exp=%0d", i, kif.fifo_count, i + 1);
            end
        end
        n_tests++;
        if (kif.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%b exp=0", kif.cmd_ready); end
        kif.cmd_index = vals[4];
        tick();
        n_tests++;
        if (kif.fifo_count !== 3'd4 || kif.press_active !== 1'b0) begin
            n_fail++;
            $display("FAIL full_holdoff got count=%0d act=%b exp count=4 act=0", kif.fifo_count, kif.press_active);
        end
        kif.en = 1'b1;
        prev = 1'b0;
        for (int t = 0; t < 80 && st_idx.size() < 5; t++) begin
            acc = kif.cmd_valid && kif.cmd_ready;
            tick();
            if (acc) kif.cmd_valid = 1'b0;
            if (kif.press_active && !prev) begin
                st_idx.push_back(kif.press_index);
                st_cyc.push_back(ecount);
            end
            prev = kif.press_active;
        end
        n_tests++;
        if (st_idx.size() != 5) begin
            n_fail++; $display("FAIL full_press_count got=%0d exp=5", st_idx.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_tests++;
                if (st_idx[i] !== vals[i]) begin
                    n_fail++; $display("FAIL full_order i=%0d got=%h exp=%h", i, st_idx[i], vals[i]);
                end
                if (i > 0) begin
                    n_tests++;
                    if (st_cyc[i] - st_cyc[i-1] != c_hold + c_gap + 1) begin
                        n_fail++;
                        $display("FAIL full_spacing i=%0d got=%0d exp=%0d", i, st_cyc[i] - st_cyc[i-1], c_hold + c_gap + 1);
                    end
                end
            end
        end
        for (int k = 0; k < 40 && kif.busy; k++) tick();
        n_tests++;
        if (kif.busy !== 1'b0) begin n_fail++; $display("FAIL full_drain busy got=%b exp=0", kif.busy); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_en_drop();
        kif.en = 1'b1; kif.cmd_index = 4'h3; kif.cmd_valid = 1'b1;
        tick();
        kif.cmd_index = 4'h9;
        tick();
        kif.cmd_valid = 1'b0;
        for (int cyc = 2; cyc <= 13; cyc++) begin
            if (cyc == 3) kif.en = 1'b0;
            n_tests++;
            if (kif.press_active !== ((cyc >= 2 && cyc <= 5) || cyc == 13)) begin
                n_fail++;
                $display("FAIL endrop_active cyc=%0d got=%b exp=%b", cyc, kif.press_active,
                         ((cyc >= 2 && cyc <= 5) || cyc == 13));
            end
            if (cyc == 2 || cyc == 13) begin
                n_tests++;
                if (kif.press_index !== ((cyc == 2) ? 4'h3 : 4'h9)) begin
                    n_fail++;
                    $display("FAIL endrop_index cyc=%0d got=%h exp=%h", cyc, kif.press_index, (cyc == 2) ? 4'h3 : 4'h9);
                end
            end
            if (cyc >= 6 && cyc <= 12) begin
                n_tests++;
                if (kif.busy !== 1'b1 || kif.fifo_count !== 3'd1) begin
                    n_fail++;
                    $display("FAIL endrop_held cyc=%0d got busy=%b count=%0d exp busy=1 count=1",
                             cyc, kif.busy, kif.fifo_count);
                end
            end
            if (cyc == 12) kif.en = 1'b1;
            if (cyc < 13) tick();
        end
        for (int k = 0; k < 40 && kif.busy; k++) tick();
        n_tests++;
        if (kif.busy !== 1'b0) begin n_fail++; $display("FAIL endrop_drain busy got=%b exp=0", kif.busy); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_row_priority();
        logic [3:0] rows [6];
        logic [3:0] exps [6];
        rows[0] = 4'b0011; exps[0] = 4'b1011;
        rows[1] = 4'b1111; exps[1] = 4'b1111;
        rows[2] = 4'b0110; exps[2] = 4'b1011;
        rows[3] = 4'b1010; exps[3] = 4'b1111;
        rows[4] = 4'b1110; exps[4] = 4'b1111;
        rows[5] = 4'b0111; exps[5] = 4'b1011;
        kif.en = 1'b1; kif.cmd_index = 4'h1; kif.cmd_valid = 1'b1;
        tick();
        kif.cmd_valid = 1'b0;
        tick();
        n_tests++;
        if (kif.press_active !== 1'b1) begin n_fail++; $display("FAIL prio_active got=%b exp=1", kif.press_active); end
        for (int i = 0; i < 6; i++) begin
            kif.keyboard_row = rows[i];
            #1;
            n_tests++;
            if (kif.keyboard_col !== exps[i]) begin
                n_fail++; $display("FAIL prio_col row=%b got=%b exp=%b", rows[i], kif.keyboard_col, exps[i]);
            end
        end
        kif.keyboard_row = 4'b1111;
        for (int k = 0; k < 40 && kif.busy; k++) tick();
        n_tests++;
        if (kif.busy !== 1'b0) begin n_fail++; $display("FAIL prio_drain busy got=%b exp=0", kif.busy); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid_press();
        bit seen;
        kif.en = 1'b1; kif.cmd_index = 4'hA; kif.cmd_valid = 1'b1;
        tick();
        kif.cmd_index = 4'hB;
        tick();
        kif.cmd_index = 4'hC;
        tick();
        kif.cmd_valid = 1'b0;
        n_tests++;
        if (kif.fifo_count !== 3'd2 || kif.press_active !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre got count=%0d act=%b exp count=2 act=1", kif.fifo_count, kif.press_active);
        end
        kif.keyboard_row = 4'b1101;
        #1;
        n_tests++;
        if (kif.keyboard_col !== 4'b1101) begin
            n_fail++; $display("FAIL rstmid_col_pre got=%b exp=1101", kif.keyboard_col);
        end
        rst_n = 1'b0;
        tick();
        n_tests++;
        if (kif.press_active !== 1'b0 || kif.keyboard_col !== 4'b1111 || kif.fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL rstmid_post got act=%b col=%b count=%0d exp act=0 col=1111 count=0",
                     kif.press_active, kif.keyboard_col, kif.fifo_count);
        end
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (kif.press_active) seen = 1'b1;
        end
        n_tests++;
        if (seen || kif.busy !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_stale got replay=%b busy=%b exp replay=0 busy=0", seen, kif.busy);
        end
        kif.keyboard_row = 4'b1111;
    endtask

    // ------------------------------------------------------------------
    task automatic test_random();
        logic [3:0] row;
        rst_n = 1'b0; kif.cmd_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 600; n++) begin
            rst_n         = ($urandom_range(0, 149) != 0);
            kif.en        = ($urandom_range(0, 4) != 0);
            kif.cmd_valid = (n < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 11) == 0);
            kif.cmd_index = 4'($urandom_range(0, 15));
            tick();
            n_tests++;
            if (kif.press_active !== m_active()) begin
                n_fail++; $display("FAIL rand_active n=%0d got=%b exp=%b", n, kif.press_active, m_active());
            end
            n_tests++;
            if (kif.press_index !== m_idx) begin
                n_fail++; $display("FAIL rand_index n=%0d got=%h exp=%h", n, kif.press_index, m_idx);
            end
            n_tests++;
            if (kif.release_pulse !== m_release()) begin
                n_fail++; $display("FAIL rand_release n=%0d got=%b exp=%b", n, kif.release_pulse, m_release());
            end
            n_tests++;
            if (kif.busy !== m_busy()) begin
                n_fail++; $display("FAIL rand_busy n=%0d got=%b exp=%b", n, kif.busy, m_busy());
            end
            n_tests++;
            if (kif.fifo_count !== 3'(mq.size())) begin
                n_fail++; $display("FAIL rand_count n=%0d got=%0d exp=%0d", n, kif.fifo_count, mq.size());
            end
            n_tests++;
            if (kif.cmd_ready !== (mq.size() != c_depth)) begin
                n_fail++; $display("FAIL rand_ready n=%0d got=%b exp=%b", n, kif.cmd_ready, (mq.size() != c_depth));
            end
            if ($urandom_range(0, 1) == 0) begin
                row = 4'b1111;
                row[$urandom_range(0, 3)] = 1'b0;
            end else begin
                row = 4'($urandom_range(0, 15));
            end
            kif.keyboard_row = row;
            #1;
            n_tests++;
            if (kif.keyboard_col !== exp_col(row, m_active(), m_idx)) begin
                n_fail++;
                $display("FAIL rand_col n=%0d row=%b got=%b exp=%b", n, row, kif.keyboard_col,
                         exp_col(row, m_active(), m_idx));
            end
        end
        rst_n = 1'b1;
        kif.cmd_valid = 1'b0;
        kif.keyboard_row = 4'b1111;
    endtask

    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_single_press();
        test_fifo_full();
        test_en_drop();
        test_row_priority();
        test_reset_mid_press();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
